uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between N_REQ byte requesters using round-robin arbitration with bounded bursts.
- Sits between client logic and the serial transmitter: captures a byte from the granted client, pulses the transmitter start, waits for completion, then re-arbitrates.
- Adds a completion timeout so a hung transmitter cannot lock out clients.

Parameters:
- N_REQ, 4, number of requesters (2..8); OW = $clog2(N_REQ) is derived.
- DW, 8, data byte width.
- MAX_BURST, 4, maximum consecutive bytes one owner may send before arbitration is forced (1..15).
- TIMEOUT, 2048, cycles allowed in WAIT for tx_done before abort (fits a 12-bit counter).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-client request; held high with data stable until gnt.
- req_data  in  N_REQ*DW  client bytes, client i at [i*DW +: DW].
- gnt  out  N_REQ  one-hot, one-cycle pulse: byte captured this cycle.
- tx_start  out  1  one-cycle start pulse to transmitter.
- tx_data  out  DW  byte to transmit; stable from capture until tx_done.
- tx_busy  in  1  transmitter busy.
- tx_done  in  1  transmitter completion pulse.
- owner  out  OW  index of current or last owner.
- active  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- All outputs are registered. Reset values: gnt=0, tx_start=0, tx_data=0, owner=0, active=0, err=0. Internal state: last=N_REQ-1 (so client 0 wins first), burst_cnt=0, to_cnt=0, state=IDLE.
- States are IDLE, START and WAIT.
- IDLE:
  - If req is nonzero, select the first asserted index searching last+1, last+2, … modulo N_REQ.
  - On that edge: owner=sel, tx_data=req_data[sel], gnt[sel]=1, burst_cnt=1, go START.
  - If req is zero, stay in IDLE.
- START:
  - tx_start=1 for exactly this one cycle.
  - to_cnt cleared; go WAIT.
- WAIT:
  - to_cnt increments each cycle.
  - On tx_done=1:
    - If req[owner]=1 and burst_cnt<MAX_BURST: capture req_data[owner], pulse gnt[owner], burst_cnt++, go START.
    - Otherwise: last=owner, go IDLE.
  - On to_cnt reaching TIMEOUT-1 without tx_done: err=1, last=owner, go IDLE.
  - tx_done arriving in the same cycle as the timeout takes priority; no err is raised.
- Latency:
  - req rises at cycle t in IDLE → gnt and tx_data at t+1, tx_start at t+2.
  - tx_done at cycle u → next gnt at u+1 (burst continue) or IDLE at u+1. Re-arbitration from IDLE costs one cycle.
- tx_done or tx_busy seen in IDLE or START is ignored. tx_busy is informational only; sequencing uses tx_done.
- A requester dropping req while not yet granted is simply skipped. Dropping req after gnt ends its burst at the next tx_done.
- The gnt pulse is the only capture handshake. A client must advance its data or drop req in the cycle after gnt.
- Fairness: after a burst ends, the owner has lowest priority. Any requester waits at most (N_REQ-1)*MAX_BURST bytes.
- Reset asserted mid-transfer returns everything to reset values immediately. No tx_start is issued until a fresh request is seen after rst_n deasserts.
- owner holds its value in IDLE.

Test Plan:
- Single client: req=4'b0100 with data 0x5A, tx_done 10 cycles after tx_start → gnt=4'b0100 one cycle, tx_data=0x5A, one tx_start, owner=2, active drops the cycle after tx_done.
- Round robin: req=4'b1111 held, every client always has data, MAX_BURST=1 → grant order 0,1,2,3,0 and each gnt is followed by exactly one tx_start.
- Burst cap: only client 1 requests continuously, MAX_BURST=4, client 3 requests during the second byte → client 1 sends 4 bytes (0x10..0x13), then client 3 is granted.
- Timeout: tx_done never asserted, TIMEOUT=16 → err pulses 16 cycles after tx_start, FSM returns to IDLE, and the next request is granted normally.
- Simultaneous tx_done and timeout edge → no err pulse; normal continue or IDLE transition.
- Reset mid-WAIT: rst_n low for 2 cycles → all outputs 0, active=0; after release with req=4'b0001, client 0 is granted.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ clients.
// Ports: clk, rst_n, req/req_data (clients), gnt, tx_* (transmitter), owner, active, err.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 2048,
  localparam int OW       = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    gnt,
  output logic                tx_start,
  output logic [DW-1:0]       tx_data,
  input  logic                tx_busy,
  input  logic                tx_done,
  output logic [OW-1:0]       owner,
  output logic                active,
  output logic                err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [11:0] TO_LAST = 12'(TIMEOUT - 1);
  localparam logic [3:0]  MB      = 4'(MAX_BURST);

  logic [1:0]    state;
  logic [OW-1:0] last;
  logic [OW-1:0] sel;
  logic [3:0]    burst_cnt;
  logic [11:0]   to_cnt;
  int            idx_w;

  // sequencing relies on tx_done only
  logic unused_busy;
  assign unused_busy = tx_busy;

  // first requester after the previous owner, wrapping
  always_comb begin
    sel   = '0;
    idx_w = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx_w = int'(last) + 1 + i;
      if (idx_w >= N_REQ) idx_w = idx_w - N_REQ;
      if (req[idx_w[OW-1:0]]) sel = idx_w[OW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      gnt       <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      owner     <= '0;
      active    <= 1'b0;
      err       <= 1'b0;
      last      <= OW'(N_REQ - 1);
      burst_cnt <= '0;
      to_cnt    <= '0;
    end else begin
      gnt      <= '0;
      tx_start <= 1'b0;
      err      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (|req) begin
            owner     <= sel;
            tx_data   <= req_data[int'(sel)*DW +: DW];
            gnt       <= N_REQ'(1) << sel;
            burst_cnt <= 4'd1;
            active    <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          tx_start <= 1'b1;
          to_cnt   <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // completion wins over a coincident timeout
          if (tx_done) begin
            if (req[owner] && burst_cnt < MB) begin
              tx_data   <= req_data[int'(owner)*DW +: DW];
              gnt       <= N_REQ'(1) << owner;
              burst_cnt <= burst_cnt + 4'd1;
              state     <= S_START;
            end else begin
              last   <= owner;
              active <= 1'b0;
              state  <= S_IDLE;
            end
          end else if (to_cnt == TO_LAST) begin
            err    <= 1'b1;
            last   <= owner;
            active <= 1'b0;
            state  <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 12'd1;
          end
        end
        default: begin
          active <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter.
// Table of arbitration vectors plus hand-written burst/timeout/reset sequences.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic [1:0]  owner;
  logic        active;
  logic        err;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ(4), .DW(8), .MAX_BURST(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .owner(owner),
    .active(active), .err(err)
  );

  typedef struct {
    logic [3:0] req;
    logic [1:0] exp_owner;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic set_d(input int i, input logic [7:0] v);
    req_data[i*8 +: 8] = v;
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    while (gnt == 4'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (gnt == 4'b0) begin
      nvec++;
      nmis++;
      $display("FAIL gnt_wait: no gnt after %0d cycles", n);
    end
  endtask

  // returns at the negedge after the tx_done cycle
  task automatic do_byte(input int dly, output int starts, output int errs);
    starts = 0;
    errs   = 0;
    tx_busy = 1'b1;
    repeat (dly) begin
      @(negedge clk);
      if (tx_start) starts++;
      if (err) errs++;
    end
    tx_done = 1'b1;
    @(negedge clk);
    if (tx_start) starts++;
    if (err) errs++;
    tx_done = 1'b0;
    tx_busy = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_gnt"}, 32'(gnt), 0);
    chk({nm, "_start"}, 32'(tx_start), 0);
    chk({nm, "_data"}, 32'(tx_data), 0);
    chk({nm, "_owner"}, 32'(owner), 0);
    chk({nm, "_active"}, 32'(active), 0);
    chk({nm, "_err"}, 32'(err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, st, er, k, m;
    int c1;
    logic [1:0] o_q [5];
    logic [7:0] d_q [5];
    logic [1:0] exp_o [5];
    logic [7:0] exp_d [5];

    tbl[0]  = '{4'b1111, 2'd3};
    tbl[1]  = '{4'b1111, 2'd0};
    tbl[2]  = '{4'b1111, 2'd1};
    tbl[3]  = '{4'b1111, 2'd2};
    tbl[4]  = '{4'b1111, 2'd3};
    tbl[5]  = '{4'b0011, 2'd0};
    tbl[6]  = '{4'b0011, 2'd1};
    tbl[7]  = '{4'b0011, 2'd0};
    tbl[8]  = '{4'b1000, 2'd3};
    tbl[9]  = '{4'b1000, 2'd3};
    tbl[10] = '{4'b0110, 2'd1};
    tbl[11] = '{4'b0110, 2'd2};

    exp_o = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3};
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h77};

    req = 4'b0; req_data = 32'b0;
    tx_done = 1'b0; tx_busy = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // single client, done 10 cycles after start
    set_d(2, 8'h5A);
    req = 4'b0100;
    wait_gnt(n);
    chk("t1_lat", n, 1);
    chk("t1_gnt", 32'(gnt), 32'h4);
    chk("t1_data", 32'(tx_data), 32'h5A);
    chk("t1_owner", 32'(owner), 2);
    chk("t1_active", 32'(active), 1);
    chk("t1_nostart", 32'(tx_start), 0);
    req = 4'b0;
    do_byte(10, st, er);
    chk("t1_starts", st, 1);
    chk("t1_active_drop", 32'(active), 0);
    chk("t1_data_hold", 32'(tx_data), 32'h5A);
    chk("t1_owner_hold", 32'(owner), 2);

    // round-robin table, one byte per grant
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int i = 0; i < 12; i++) begin
      req = tbl[i].req;
      wait_gnt(n);
      chk($sformatf("rr%0d_owner", i), 32'(owner),
          32'(tbl[i].exp_owner));
      chk($sformatf("rr%0d_gnt", i), 32'(gnt),
          32'(4'b0001 << tbl[i].exp_owner));
      chk($sformatf("rr%0d_data", i), 32'(tx_data),
          32'(8'hA0 + 8'(tbl[i].exp_owner)));
      req = 4'b0;
      do_byte(4, st, er);
      chk($sformatf("rr%0d_starts", i), st, 1);
      @(negedge clk);
    end

    // burst cap: client 1 streams, client 3 joins on byte 2
    c1 = 8'h10;
    set_d(1, 8'(c1));
    req = 4'b0010;
    for (int b = 0; b < 5; b++) begin
      wait_gnt(n);
      o_q[b] = owner;
      d_q[b] = tx_data;
      if (gnt[1]) begin
        c1++;
        set_d(1, 8'(c1));
      end
      if (b == 1) begin
        set_d(3, 8'h77);
        req[3] = 1'b1;
      end
      if (b == 4) req = 4'b0;
      do_byte(3, st, er);
    end
    for (int b = 0; b < 5; b++) begin
      chk($sformatf("burst%0d_owner", b), 32'(o_q[b]), 32'(exp_o[b]));
      chk($sformatf("burst%0d_data", b), 32'(d_q[b]), 32'(exp_d[b]));
    end
    chk("burst_end_active", 32'(active), 0);

    // timeout: tx_done never comes
    set_d(0, 8'hC3);
    req = 4'b0001;
    wait_gnt(n);
    chk("to_owner", 32'(owner), 0);
    req = 4'b0;
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (!tx_start && m < 5);
    chk("to_start", 32'(tx_start), 1);
    k = 0;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (err) begin
        k = j;
        break;
      end
    end
    chk("to_err_delay", k, 16);
    chk("to_active", 32'(active), 0);
    @(negedge clk);
    chk("to_err_pulse", 32'(err), 0);
    set_d(1, 8'h44);
    req = 4'b0010;
    wait_gnt(n);
    chk("to_next_owner", 32'(owner), 1);
    chk("to_next_data", 32'(tx_data), 32'h44);
    req = 4'b0;
    do_byte(4, st, er);
    chk("to_next_err", er, 0);

    // tx_done on the timeout edge: continue, no err
    set_d(2, 8'h60);
    req = 4'b0100;
    wait_gnt(n);
    chk("sim_owner", 32'(owner), 2);
    set_d(2, 8'h61);
    do_byte(16, st, er);
    chk("sim_err", er, 0);
    chk("sim_gnt", 32'(gnt), 32'h4);
    chk("sim_data", 32'(tx_data), 32'h61);
    req = 4'b0;
    do_byte(3, st, er);
    chk("sim_err2", er, 0);
    chk("sim_idle", 32'(active), 0);

    // reset in the middle of WAIT
    set_d(3, 8'h99);
    req = 4'b1000;
    wait_gnt(n);
    chk("rst_owner", 32'(owner), 3);
    req = 4'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("rst_rel");
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    st = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx_start || active) st++;
    end
    chk("rst_quiet", st, 0);
    set_d(0, 8'hD0);
    req = 4'b1001;
    wait_gnt(n);
    chk("rst_gnt", 32'(gnt), 32'h1);
    chk("rst_data", 32'(tx_data), 32'hD0);
    req = 4'b0;
    do_byte(4, st, er);
    chk("rst_starts", st, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
